// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: widths, op and state encodings.
package mult_div_unit_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  // Encodings match the decode stage's view of the HI/LO ops.
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: one shift-add (multiply) or restoring-subtract (divide)
// step per cycle on unsigned magnitudes, with accumulator and iteration counter.
module mdu_iter_core #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [2*W-1:0]   acc_o,
  output logic [CNT_W-1:0] iter_o
);

  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [W:0]       sum;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;

  // Next accumulator: load magnitudes, or advance one multiply/divide step.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    iter_d = iter_q;
    sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
    rem_sh = acc_q[2*W-1:W-1];
    diff   = rem_sh - {1'b0, opnd_q};
    if (load_i) begin
      // Multiply holds the multiplier in the low half; divide holds the dividend.
      acc_d  = is_div_i ? {W'(0), a_i} : {W'(0), b_i};
      opnd_d = is_div_i ? b_i : a_i;
      div_d  = is_div_i;
      iter_d = CNT_W'(W - 1);
    end else if (step_i) begin
      iter_d = iter_q - CNT_W'(1);
      if (div_q) begin
        if (!diff[W]) begin
          acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum, acc_q[W-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      iter_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      iter_q <= iter_d;
    end
  end

  assign acc_o  = acc_q;
  assign iter_o = iter_q;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit: control FSM, sign handling and architectural HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             bzero_q, bzero_d;
  logic             div_q, div_d;

  logic             core_load, core_step;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] iter;

  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  mdu_iter_core #(
    .W     (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (core_load),
    .step_i   (core_step),
    .is_div_i (op[1]),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .acc_o    (acc),
    .iter_o   (iter)
  );

  // Next state, operand magnitudes, sign correction and HI/LO write path.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    bzero_d   = bzero_q;
    div_d     = div_q;
    core_load = 1'b0;
    core_step = 1'b0;

    is_signed = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
    a_neg     = is_signed && op_a[WIDTH-1];
    b_neg     = is_signed && op_b[WIDTH-1];
    a_mag     = a_neg ? WIDTH'(0) - op_a : op_a;
    b_mag     = b_neg ? WIDTH'(0) - op_b : op_b;

    prod = neg_q_q ? PW'(0) - acc : acc;
    quo  = neg_q_q ? WIDTH'(0) - acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r_q ? WIDTH'(0) - acc[PW-1:WIDTH] : acc[PW-1:WIDTH];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (mthi) hi_d = wr_data;
        if (mtlo) lo_d = wr_data;
        state_d = S_IDLE;
        if (start) begin
          state_d   = S_CALC;
          core_load = 1'b1;
          neg_q_d   = a_neg ^ b_neg;
          neg_r_d   = a_neg;
          bzero_d   = (op_b == WIDTH'(0));
          div_d     = op[1];
        end
      end
      S_CALC: begin
        core_step = 1'b1;
        if (iter == CNT_W'(0)) state_d = S_SIGN;
      end
      S_SIGN: begin
        state_d = S_DONE;
        if (div_q) begin
          // Divide by zero leaves the dividend in HI and all ones in LO.
          hi_d = rem;
          lo_d = bzero_q ? {WIDTH{1'b1}} : quo;
        end else begin
          hi_d = prod[PW-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_SIGN);
    done_d = (state_d == S_DONE);
  end

  // Control and architectural registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bzero_q <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      bzero_q <= bzero_d;
      div_q   <= div_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed table, corner sequences, random ops vs model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] op_a = '0, op_b = '0, wr_data = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {hi,lo} computed directly from the op definitions.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Launch one op and wait for done; edges counts the start edge as 1.
  // With now=1 the start is driven in the current (done) cycle for back-to-back issue.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit now, output int edges);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; op = 2'($urandom_range(0, 3));
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[$];
  int   lat;
  logic [63:0] exp64;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);

    // Directed vectors from the op definitions
    vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'd2, 32'h0000_0019, 32'h0000_0000, 32'h0000_0019, 32'hFFFF_FFFF});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{2'd2, 32'hFFFF_FFE7, 32'h0000_0000, 32'hFFFF_FFE7, 32'hFFFF_FFFF});
    vecs.push_back('{2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF});
    vecs.push_back('{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    vecs.push_back('{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Start and mthi while busy are ignored
    @(negedge clk);
    start = 1'b1; op = 2'd1; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'd3; op_a = 32'd100; op_b = 32'd7; mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("busy_ignore_busy", 32'(busy), 32'h1);
    chk("busy_ignore_hi_nowrite", hi, 32'h0000_000F);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ignore_timeout", 32'(lat < 100), 32'h1);
    chk("busy_ignore_hi", hi, 32'h0);
    chk("busy_ignore_lo", lo, 32'd30);
    @(negedge clk);
    chk("busy_ignore_no_restart", 32'(busy), 32'h0);

    // mtlo while idle
    mtlo = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi_kept", hi, 32'h0);

    // mthi with start: write lands, then the result overwrites it
    start = 1'b1; op = 2'd1; op_a = 32'd2; op_b = 32'd3; mthi = 1'b1; wr_data = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("mthi_start_hi", hi, 32'hCAFE_0001);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("mthi_start_res_hi", hi, 32'h0);
    chk("mthi_start_res_lo", lo, 32'd6);

    // Reset mid-op discards the op and clears HI/LO at once
    @(negedge clk);
    mtlo = 1'b1; mthi = 1'b1; wr_data = 32'h5555_AAAA;
    @(negedge clk);
    mtlo = 1'b0; mthi = 1'b0;
    start = 1'b1; op = 2'd0; op_a = 32'hFFFF_FFFD; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_op(2'd1, 32'd2, 32'd3, 1'b0, lat);
    chk("postrst_latency", 32'(lat), 32'd34);
    chk("postrst_hi", hi, 32'h0);
    chk("postrst_lo", lo, 32'd6);

    // Randomized ops, alternating idle and back-to-back issue
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      exp64 = model(ro, ra, rb);
      run_op(ro, ra, rb, (k % 2) == 1, lat);
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'd34);
      chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", k, ro, ra, rb), hi, exp64[63:32]);
      chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", k, ro, ra, rb), lo, exp64[31:0]);
    end

    @(negedge clk);
    chk("final_idle", 32'(busy), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
